// File: rtl/adat_pkg.sv
// Shared constants, state encodings and helpers for the ADAT frame-lock supervisor.
package adat_pkg;

    localparam int unsigned ADAT_FRAME_BITS     = 256;
    localparam int unsigned ADAT_LOCK_FRAMES    = 4;
    localparam int unsigned ADAT_UNLOCK_FRAMES  = 3;
    localparam int unsigned ADAT_VALID_TIMEOUT  = 64;
    localparam int unsigned ADAT_RESYNC_HOLDOFF = 16;

    localparam int unsigned IDX_W = 8;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_SEARCH   = 3'd1;
    localparam logic [ST_W-1:0] ST_VERIFY   = 3'd2;
    localparam logic [ST_W-1:0] ST_LOCKED   = 3'd3;
    localparam logic [ST_W-1:0] ST_HOLDOVER = 3'd4;

    // Lock is reported in both the locked and the holdover state.
    function automatic logic state_is_locked(input logic [ST_W-1:0] st);
        return (st == ST_LOCKED) || (st == ST_HOLDOVER);
    endfunction

endpackage

// File: rtl/adat_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module adat_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o
);

    // Count up on inc_i, stick at all-ones, clear to zero on clear_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_o <= '0;
        end else if (clear_i) begin
            count_o <= '0;
        end else if (inc_i && (count_o != '1)) begin
            count_o <= count_o + WIDTH'(1);
        end
    end

endmodule

// File: rtl/adat_frame_lock_controller.sv
// Supervises the ADAT NRZI decoder: checks sync spacing, declares and drops frame lock
// with hysteresis, requests decoder resync on loss of lock and supplies bit timing.
module adat_frame_lock_controller
    import adat_pkg::*;
#(
    parameter int unsigned FRAME_BITS     = ADAT_FRAME_BITS,
    parameter int unsigned LOCK_FRAMES    = ADAT_LOCK_FRAMES,
    parameter int unsigned UNLOCK_FRAMES  = ADAT_UNLOCK_FRAMES,
    parameter int unsigned VALID_TIMEOUT  = ADAT_VALID_TIMEOUT,
    parameter int unsigned RESYNC_HOLDOFF = ADAT_RESYNC_HOLDOFF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic             data_i,
    input  logic             valid_i,
    input  logic             sync_i,
    output logic             resync_o,
    output logic             lock_o,
    output logic             frame_start_o,
    output logic [IDX_W-1:0] bit_index_o,
    output logic             bit_o,
    output logic             bit_valid_o,
    output logic [ERR_W-1:0] error_count_o,
    output logic [ST_W-1:0]  state_o
);

    localparam int unsigned RUN_W = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned BAD_W = $clog2(UNLOCK_FRAMES + 1);
    localparam int unsigned TO_W  = $clog2(VALID_TIMEOUT + 1);
    localparam int unsigned HO_W  = $clog2(RESYNC_HOLDOFF + 1);

    logic [ST_W-1:0]  state_q,       state_d;
    logic [IDX_W-1:0] bit_cnt_q,     bit_cnt_d;
    logic [RUN_W-1:0] good_run_q,    good_run_d;
    logic [BAD_W-1:0] bad_run_q,     bad_run_d;
    logic [TO_W-1:0]  to_cnt_q,      to_cnt_d;
    logic [HO_W-1:0]  holdoff_q,     holdoff_d;
    logic             resync_q,      resync_d;
    logic             lock_q,        lock_d;
    logic             frame_start_q, frame_start_d;
    logic             bit_q,         bit_d;
    logic             bit_valid_q,   bit_valid_d;

    logic             accept;
    logic             at_end;
    logic             good_frame;
    logic             bad_frame;
    logic             err_inc;

    // Next-state and next-output logic for the lock FSM and its counters.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        to_cnt_d   = to_cnt_q;
        holdoff_d  = holdoff_q;
        resync_d   = 1'b0;
        bit_d      = bit_q;
        accept     = 1'b0;
        err_inc    = 1'b0;

        at_end     = (bit_cnt_q == IDX_W'(FRAME_BITS - 1));
        good_frame = valid_i & sync_i & at_end;
        // Sync off the expected slot, or the expected slot passing without a sync.
        bad_frame  = valid_i & (sync_i ^ at_end);

        if (!enable_i || (state_q == ST_IDLE)) begin
            state_d    = enable_i ? ST_SEARCH : ST_IDLE;
            bit_cnt_d  = '0;
            good_run_d = '0;
            bad_run_d  = '0;
            to_cnt_d   = '0;
            holdoff_d  = '0;
            bit_d      = 1'b0;
        end else if (holdoff_q != '0) begin
            holdoff_d  = holdoff_q - HO_W'(1);
            bit_cnt_d  = '0;
            good_run_d = '0;
            bad_run_d  = '0;
            to_cnt_d   = '0;
            bit_d      = 1'b0;
        end else if (!valid_i) begin
            if (to_cnt_q == TO_W'(VALID_TIMEOUT - 1)) begin
                state_d    = ST_SEARCH;
                resync_d   = 1'b1;
                holdoff_d  = HO_W'(RESYNC_HOLDOFF);
                bit_cnt_d  = '0;
                good_run_d = '0;
                bad_run_d  = '0;
                to_cnt_d   = '0;
                bit_d      = 1'b0;
                err_inc    = lock_q;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            accept    = 1'b1;
            to_cnt_d  = '0;
            bit_d     = data_i;
            bit_cnt_d = (sync_i || at_end) ? '0 : bit_cnt_q + IDX_W'(1);
            case (state_q)
                ST_SEARCH: begin
                    if (sync_i) begin
                        state_d    = ST_VERIFY;
                        good_run_d = '0;
                    end
                end
                ST_VERIFY: begin
                    if (good_frame) begin
                        if (good_run_q == RUN_W'(LOCK_FRAMES - 1)) begin
                            state_d    = ST_LOCKED;
                            good_run_d = '0;
                        end else begin
                            good_run_d = good_run_q + RUN_W'(1);
                        end
                    end else if (bad_frame) begin
                        good_run_d = '0;
                        err_inc    = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (bad_frame) begin
                        state_d   = ST_HOLDOVER;
                        bad_run_d = BAD_W'(1);
                        err_inc   = 1'b1;
                    end
                end
                ST_HOLDOVER: begin
                    if (good_frame) begin
                        state_d   = ST_LOCKED;
                        bad_run_d = '0;
                    end else if (bad_frame) begin
                        err_inc = 1'b1;
                        if (bad_run_q == BAD_W'(UNLOCK_FRAMES - 1)) begin
                            state_d    = ST_SEARCH;
                            resync_d   = 1'b1;
                            holdoff_d  = HO_W'(RESYNC_HOLDOFF);
                            bit_cnt_d  = '0;
                            good_run_d = '0;
                            bad_run_d  = '0;
                        end else begin
                            bad_run_d = bad_run_q + BAD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        lock_d        = state_is_locked(state_d);
        frame_start_d = accept & sync_i & lock_d;
        bit_valid_d   = accept & lock_d;
    end

    // State, counter and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            good_run_q    <= '0;
            bad_run_q     <= '0;
            to_cnt_q      <= '0;
            holdoff_q     <= '0;
            resync_q      <= 1'b0;
            lock_q        <= 1'b0;
            frame_start_q <= 1'b0;
            bit_q         <= 1'b0;
            bit_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            good_run_q    <= good_run_d;
            bad_run_q     <= bad_run_d;
            to_cnt_q      <= to_cnt_d;
            holdoff_q     <= holdoff_d;
            resync_q      <= resync_d;
            lock_q        <= lock_d;
            frame_start_q <= frame_start_d;
            bit_q         <= bit_d;
            bit_valid_q   <= bit_valid_d;
        end
    end

    adat_sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (err_inc),
        .clear_i (clear_i),
        .count_o (error_count_o)
    );

    assign state_o       = state_q;
    assign bit_index_o   = bit_cnt_q;
    assign resync_o      = resync_q;
    assign lock_o        = lock_q;
    assign frame_start_o = frame_start_q;
    assign bit_o         = bit_q;
    assign bit_valid_o   = bit_valid_q;

endmodule

// File: tb/tb_adat_frame_lock_controller.sv
// Directed bench for the ADAT frame-lock supervisor with a queue of expected outputs.
module tb_adat_frame_lock_controller;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        clear_i;
    logic        data_i;
    logic        valid_i;
    logic        sync_i;
    logic        resync_o;
    logic        lock_o;
    logic        frame_start_o;
    logic [7:0]  bit_index_o;
    logic        bit_o;
    logic        bit_valid_o;
    logic [15:0] error_count_o;
    logic [2:0]  state_o;

    localparam int SEL_STATE  = 0;
    localparam int SEL_LOCK   = 1;
    localparam int SEL_RESYNC = 2;
    localparam int SEL_FS     = 3;
    localparam int SEL_IDX    = 4;
    localparam int SEL_ERR    = 5;
    localparam int SEL_BV     = 6;
    localparam int SEL_BIT    = 7;

    typedef struct {
        string       tag;
        int          sel;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    adat_frame_lock_controller dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .clear_i       (clear_i),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .sync_i        (sync_i),
        .resync_o      (resync_o),
        .lock_o        (lock_o),
        .frame_start_o (frame_start_o),
        .bit_index_o   (bit_index_o),
        .bit_o         (bit_o),
        .bit_valid_o   (bit_valid_o),
        .error_count_o (error_count_o),
        .state_o       (state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_STATE:  return 16'(state_o);
            SEL_LOCK:   return 16'(lock_o);
            SEL_RESYNC: return 16'(resync_o);
            SEL_FS:     return 16'(frame_start_o);
            SEL_IDX:    return 16'(bit_index_o);
            SEL_ERR:    return error_count_o;
            SEL_BV:     return 16'(bit_valid_o);
            SEL_BIT:    return 16'(bit_o);
            default:    return 16'hDEAD;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [15:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input logic v, input logic s, input logic d);
        valid_i = v;
        sync_i  = s;
        data_i  = d;
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom_range(1, 0)));
    endtask

    task automatic good_frame();
        send_bits(255);
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst_i    = 1'b1;
        enable_i = 1'b0;
        clear_i  = 1'b0;
        data_i   = 1'b0;
        valid_i  = 1'b0;
        sync_i   = 1'b0;

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        push_exp("rst_state",  SEL_STATE,  16'd0);
        push_exp("rst_lock",   SEL_LOCK,   16'd0);
        push_exp("rst_resync", SEL_RESYNC, 16'd0);
        push_exp("rst_idx",    SEL_IDX,    16'd0);
        push_exp("rst_err",    SEL_ERR,    16'd0);
        push_exp("rst_bv",     SEL_BV,     16'd0);
        check_all();
        rst_i    = 1'b0;
        enable_i = 1'b1;

        // IDLE -> SEARCH, then clean stream to lock
        push_exp("en_search", SEL_STATE, 16'd1);
        step(1'b0, 1'b0, 1'b0);
        push_exp("sync1_verify", SEL_STATE, 16'd2);
        push_exp("sync1_idx",    SEL_IDX,   16'd0);
        push_exp("sync1_lock",   SEL_LOCK,  16'd0);
        step(1'b1, 1'b1, 1'b0);
        good_frame();
        good_frame();
        send_bits(255);
        push_exp("sync4_state", SEL_STATE, 16'd2);
        push_exp("sync4_lock",  SEL_LOCK,  16'd0);
        step(1'b1, 1'b1, 1'b0);
        send_bits(255);
        push_exp("sync5_lock",  SEL_LOCK,  16'd1);
        push_exp("sync5_state", SEL_STATE, 16'd3);
        push_exp("sync5_fs",    SEL_FS,    16'd1);
        push_exp("sync5_bv",    SEL_BV,    16'd1);
        push_exp("sync5_idx",   SEL_IDX,   16'd0);
        step(1'b1, 1'b1, 1'b0);
        push_exp("bit1_fs",  SEL_FS,  16'd0);
        push_exp("bit1_idx", SEL_IDX, 16'd1);
        push_exp("bit1_bit", SEL_BIT, 16'd1);
        push_exp("bit1_bv",  SEL_BV,  16'd1);
        step(1'b1, 1'b0, 1'b1);
        send_bits(254);
        push_exp("sync6_fs",   SEL_FS,   16'd1);
        push_exp("sync6_lock", SEL_LOCK, 16'd1);
        push_exp("sync6_err",  SEL_ERR,  16'd0);
        step(1'b1, 1'b1, 1'b0);

        // Early sync at index 200 -> HOLDOVER, then recover
        send_bits(199);
        push_exp("early_state", SEL_STATE, 16'd4);
        push_exp("early_lock",  SEL_LOCK,  16'd1);
        push_exp("early_err",   SEL_ERR,   16'd1);
        push_exp("early_idx",   SEL_IDX,   16'd0);
        step(1'b1, 1'b1, 1'b0);
        send_bits(127);
        push_exp("hold_mid_lock", SEL_LOCK, 16'd1);
        push_exp("hold_mid_idx",  SEL_IDX,  16'd128);
        step(1'b1, 1'b0, 1'b0);
        send_bits(127);
        push_exp("recov_state", SEL_STATE, 16'd3);
        push_exp("recov_lock",  SEL_LOCK,  16'd1);
        push_exp("recov_err",   SEL_ERR,   16'd1);
        push_exp("recov_fs",    SEL_FS,    16'd1);
        step(1'b1, 1'b1, 1'b0);

        // Clear, then three missing syncs -> resync and SEARCH
        clear_i = 1'b1;
        push_exp("clear_err", SEL_ERR, 16'd0);
        step(1'b1, 1'b0, 1'b0);
        clear_i = 1'b0;
        send_bits(254);
        push_exp("miss1_state", SEL_STATE, 16'd4);
        push_exp("miss1_err",   SEL_ERR,   16'd1);
        push_exp("miss1_idx",   SEL_IDX,   16'd0);
        push_exp("miss1_lock",  SEL_LOCK,  16'd1);
        step(1'b1, 1'b0, 1'b0);
        send_bits(255);
        push_exp("miss2_state", SEL_STATE, 16'd4);
        push_exp("miss2_err",   SEL_ERR,   16'd2);
        step(1'b1, 1'b0, 1'b0);
        send_bits(255);
        push_exp("miss3_resync", SEL_RESYNC, 16'd1);
        push_exp("miss3_lock",   SEL_LOCK,   16'd0);
        push_exp("miss3_state",  SEL_STATE,  16'd1);
        push_exp("miss3_err",    SEL_ERR,    16'd3);
        push_exp("miss3_idx",    SEL_IDX,    16'd0);
        step(1'b1, 1'b0, 1'b0);
        push_exp("miss_pulse_end", SEL_RESYNC, 16'd0);
        push_exp("miss_ho1_state", SEL_STATE,  16'd1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
        push_exp("miss_ho16_state", SEL_STATE, 16'd1);
        push_exp("miss_ho16_idx",   SEL_IDX,   16'd0);
        step(1'b1, 1'b1, 1'b0);
        push_exp("miss_ho_done", SEL_STATE, 16'd2);
        step(1'b1, 1'b1, 1'b0);

        // Relock, then valid timeout while locked
        good_frame();
        good_frame();
        good_frame();
        good_frame();
        push_exp("relock_lock", SEL_LOCK, 16'd1);
        check_all();
        for (int i = 0; i < 62; i++) step(1'b0, 1'b0, 1'b0);
        push_exp("to63_lock",   SEL_LOCK,   16'd1);
        push_exp("to63_resync", SEL_RESYNC, 16'd0);
        push_exp("to63_state",  SEL_STATE,  16'd3);
        step(1'b0, 1'b0, 1'b0);
        push_exp("to64_resync", SEL_RESYNC, 16'd1);
        push_exp("to64_state",  SEL_STATE,  16'd1);
        push_exp("to64_lock",   SEL_LOCK,   16'd0);
        push_exp("to64_err",    SEL_ERR,    16'd4);
        step(1'b0, 1'b0, 1'b0);
        push_exp("to_pulse_end", SEL_RESYNC, 16'd0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
        push_exp("to_ho16_state", SEL_STATE, 16'd1);
        push_exp("to_ho16_idx",   SEL_IDX,   16'd0);
        step(1'b1, 1'b1, 1'b0);
        push_exp("to_ho_done", SEL_STATE, 16'd2);
        step(1'b1, 1'b1, 1'b0);

        // Repeated bad syncs in VERIFY drive the error count into saturation
        for (int i = 0; i < 65540; i++) step(1'b1, 1'b1, 1'b0);
        push_exp("sat_err",   SEL_ERR,   16'hFFFF);
        push_exp("sat_state", SEL_STATE, 16'd2);
        step(1'b1, 1'b1, 1'b0);
        clear_i = 1'b1;
        push_exp("clear_wins", SEL_ERR, 16'd0);
        step(1'b1, 1'b1, 1'b0);
        clear_i = 1'b0;
        push_exp("post_clear_inc", SEL_ERR, 16'd1);
        step(1'b1, 1'b1, 1'b0);

        // Asynchronous reset mid-frame
        send_bits(9);
        push_exp("pre_rst_idx", SEL_IDX, 16'd10);
        push_exp("pre_rst_bit", SEL_BIT, 16'd1);
        step(1'b1, 1'b0, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        push_exp("arst_state", SEL_STATE, 16'd0);
        push_exp("arst_idx",   SEL_IDX,   16'd0);
        push_exp("arst_err",   SEL_ERR,   16'd0);
        push_exp("arst_bit",   SEL_BIT,   16'd0);
        push_exp("arst_lock",  SEL_LOCK,  16'd0);
        check_all();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Disable mid-operation: IDLE next cycle, error count held
        push_exp("re_search", SEL_STATE, 16'd1);
        step(1'b0, 1'b0, 1'b0);
        push_exp("re_verify", SEL_STATE, 16'd2);
        step(1'b1, 1'b1, 1'b0);
        push_exp("re_bad_err", SEL_ERR, 16'd1);
        step(1'b1, 1'b1, 1'b0);
        send_bits(4);
        push_exp("re_idx5", SEL_IDX, 16'd5);
        step(1'b1, 1'b0, 1'b1);
        enable_i = 1'b0;
        push_exp("dis_state",  SEL_STATE,  16'd0);
        push_exp("dis_idx",    SEL_IDX,    16'd0);
        push_exp("dis_err",    SEL_ERR,    16'd1);
        push_exp("dis_resync", SEL_RESYNC, 16'd0);
        push_exp("dis_bit",    SEL_BIT,    16'd0);
        step(1'b1, 1'b0, 1'b1);
        push_exp("dis_stay", SEL_STATE, 16'd0);
        step(1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
